pll_fll_ctrl: RTL and testbench
===============================

Name: pll_fll_ctrl

Overview:
- Parametrised frequency-locked-loop controller for the digital PLL; the next generation of the fixed 26-bit trim / 5-bit divider loop.
- Runs on the reference oscillator. Each measurement window it compares a DCO edge count against the divider target and steps a thermometer trim code.
- Adds a lock detector, divider-change retrain and manual-trim bypass.
- Sits between the DCO edge counter (count arrives already synchronised) and the ring-oscillator trim inputs.

Parameters:
- TRIM_W, 26, trim code width; the internal level L ranges 0..TRIM_W.
- DIV_W, 5, divider/target width.
- CNT_W, 8, measured DCO count width (must be >= DIV_W).
- SETTLE_CYC, 4, osc cycles waited after each trim change before measuring (>=1).
- LOCK_CNT, 8, consecutive in-window measurements required to assert locked (>=1).
- TOL, 1, allowed |count - target| for an in-window measurement.

Ports:
- osc  in  1  reference clock; all logic on its rising edge.
- resetb  in  1  asynchronous active-low reset.
- enable  in  1  loop enable.
- dco  in  1  1 = manual mode: trim follows ext_trim.
- div  in  DIV_W  target DCO edges per measurement window.
- ext_trim  in  TRIM_W  manual trim code.
- cnt_valid  in  1  one-cycle strobe: cnt_value holds a fresh window count.
- cnt_value  in  CNT_W  DCO edges counted in the last window.
- cnt_clear  out  1  one-cycle pulse: restart the external counter.
- trim  out  TRIM_W  trim code to the DCO.
- locked  out  1  loop locked.

Behaviour:
- Reset (resetb=0, async):
  - L = TRIM_W/2 (floor); trim = (1<<L)-1.
  - locked=0, cnt_clear=0, lock counter=0, div_q=0, state OFF.
- All outputs are registered.
- Trim encoding: in auto mode trim = thermometer of L (bits [L-1:0] set). Larger L means more delay, i.e. a slower DCO.
- States: OFF, SETTLE, MEASURE, ADJUST.
- OFF:
  - Entered whenever enable=0, dco=1 or div=0; these conditions override every other state within one cycle.
  - locked=0; L is held (not reset to midscale).
  - When enable=1, dco=0 and div!=0: go to SETTLE, load div_q=div, clear the lock counter.
- SETTLE:
  - cnt_clear=1 in the first cycle only.
  - Stay SETTLE_CYC cycles, then go to MEASURE.
- MEASURE:
  - Wait for cnt_valid; cnt_valid outside MEASURE is ignored.
  - On cnt_valid, register cnt_value and go to ADJUST.
- ADJUST (one cycle), comparing the registered count c against t = div_q, using CNT_W+1-bit signed arithmetic with no underflow:
  - c > t+TOL: L = min(L+step, TRIM_W); lock counter=0; locked=0.
  - c < t-TOL (this term is 0 if t<TOL): L = max(L-step, 0); lock counter=0; locked=0.
  - Otherwise: L unchanged; lock counter increments, saturating at LOCK_CNT; locked=1 when it reaches LOCK_CNT.
  - Then go to SETTLE.
- Saturation: at L=TRIM_W (or 0) a further push in that direction leaves L unchanged and locked stays 0.
- Divider change: div != div_q while not in OFF forces SETTLE next cycle, loads div_q, clears the lock counter, locked=0 and discards any in-flight measurement. L is kept.
- Manual mode (dco=1): trim = ext_trim registered (1-cycle latency), locked=0.
  - On return to dco=0, trim resumes from the held L, not from ext_trim.
- Simultaneous events: enable fall or dco rise in the same cycle as cnt_valid drops that measurement. A div change has priority over ADJUST.
- Reset mid-operation: immediate return to reset values; no cnt_clear pulse.
- step = 1 unless the optional feature is enabled.

Optional Feature:
- Macro PLL_FLL_BINSEARCH_EN.
- Enabled:
  - step register initialised to max(TRIM_W/4,1) on reset, on OFF->SETTLE and on div change.
  - Each out-of-window ADJUST applies step, then halves it (minimum 1).
  - An in-window measurement sets step=1.
- Disabled: step is constant 1 and there is no step register.

Test Plan:
- Reset then enable=1, div=8, cnt_value=8 every window -> trim=13 ones (0x0001FFF) throughout; locked=1 at the 8th ADJUST; cnt_clear pulses once per window.
- cnt_value=12, TOL=1 -> L goes 13,14,15,... one per window, saturates at 26 (trim=0x3FFFFFF), locked stays 0. Then cnt_value=0 -> L descends to 0 (trim=0).
- Locked at div=8, then div=10 with cnt_value still 8 -> locked=0 next cycle, state SETTLE, L decrements until the model DCO returns 10, relocks after 8 in-window windows.
- dco=1, ext_trim=0x155 -> trim=0x155 one cycle later, locked=0; dco=0 -> trim returns to the prior thermometer L.
- enable=0 for 50 ns mid-MEASURE with a cnt_valid asserted -> count dropped, L unchanged, locked=0. Re-enable -> SETTLE with a cnt_clear pulse. resetb pulse mid-ADJUST -> L=13, outputs at reset values asynchronously.
- With PLL_FLL_BINSEARCH_EN, cnt_value high until L>=22, target 22 -> L steps 13,19,22 (steps 6,3) and then holds once in window.

Source files
------------

// File: rtl/pll_fll_ctrl.sv
// ============================================================================
// Module   : pll_fll_ctrl
// Brief    : Frequency-locked-loop controller. Steps a thermometer DCO trim
//            from windowed edge counts, with lock detection, divider-change
//            retrain and manual trim bypass. Optional macro:
//            PLL_FLL_BINSEARCH_EN (binary-search step sizing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_fll_ctrl #(
    parameter int TRIM_W     = 26,
    parameter int DIV_W      = 5,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int LOCK_CNT   = 8,
    parameter int TOL        = 1
) (
    input  logic              osc,
    input  logic              resetb,
    input  logic              enable,
    input  logic              dco,
    input  logic [DIV_W-1:0]  div,
    input  logic [TRIM_W-1:0] ext_trim,
    input  logic              cnt_valid,
    input  logic [CNT_W-1:0]  cnt_value,
    output logic              cnt_clear,
    output logic [TRIM_W-1:0] trim,
    output logic              locked
);

    localparam int LW = $clog2(TRIM_W + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int KW = $clog2(LOCK_CNT + 1);

    localparam logic [LW-1:0]        c_l_max    = LW'(TRIM_W);
    localparam logic [LW-1:0]        c_l_rst    = LW'(TRIM_W / 2);
    localparam logic [SW-1:0]        c_settle_l = SW'(SETTLE_CYC - 1);
    localparam logic [KW-1:0]        c_lock_max = KW'(LOCK_CNT);
    localparam logic signed [CNT_W:0] c_tol     = (CNT_W + 1)'(TOL);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_ADJUST  = 2'd3
    } state_t;

    function automatic logic [TRIM_W-1:0] therm(input logic [LW-1:0] lvl);
        logic [TRIM_W-1:0] t;
        t = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            t[i] = (i < int'(lvl));
        end
        return t;
    endfunction

    state_t            r_state, w_state_nx;
    logic [LW-1:0]     r_level, w_level_nx;
    logic [KW-1:0]     r_lock_cnt, w_lock_nx;
    logic              r_locked, w_locked_nx;
    logic              r_clear, w_clear_nx;
    logic [DIV_W-1:0]  r_div_q, w_div_nx;
    logic [SW-1:0]     r_settle, w_settle_nx;
    logic [CNT_W-1:0]  r_cnt_q, w_cnt_nx;
    logic [TRIM_W-1:0] r_trim, w_trim_nx;
    logic [LW-1:0]     w_step;

`ifdef PLL_FLL_BINSEARCH_EN
    localparam logic [LW-1:0] c_step0 = (TRIM_W / 4 >= 1) ? LW'(TRIM_W / 4) : LW'(1);
    logic [LW-1:0] r_step, w_step_nx, w_step_half;
    assign w_step      = r_step;
    assign w_step_half = (r_step > LW'(1)) ? (r_step >> 1) : LW'(1);
`else
    assign w_step = LW'(1);
`endif

    logic                  w_off;
    logic signed [CNT_W:0] w_c, w_t, w_hi, w_lo;
    logic [LW:0]           w_up_sum;
    logic [LW-1:0]         w_up, w_dn;
    logic [KW-1:0]         w_lock_inc;

    assign w_off = !enable || dco || (div == '0);

    // All operands are non-negative; the window floor clamps at zero instead of wrapping.
    assign w_c  = $signed({1'b0, r_cnt_q});
    assign w_t  = $signed({{(CNT_W + 1 - DIV_W){1'b0}}, r_div_q});
    assign w_hi = w_t + c_tol;
    assign w_lo = (w_t < c_tol) ? '0 : (w_t - c_tol);

    assign w_up_sum   = {1'b0, r_level} + {1'b0, w_step};
    assign w_up       = (w_up_sum > {1'b0, c_l_max}) ? c_l_max : w_up_sum[LW-1:0];
    assign w_dn       = (r_level <= w_step) ? '0 : (r_level - w_step);
    assign w_lock_inc = (r_lock_cnt == c_lock_max) ? r_lock_cnt : (r_lock_cnt + KW'(1));

    always_comb begin
        w_state_nx  = r_state;
        w_level_nx  = r_level;
        w_lock_nx   = r_lock_cnt;
        w_locked_nx = r_locked;
        w_clear_nx  = 1'b0;
        w_div_nx    = r_div_q;
        w_settle_nx = r_settle;
        w_cnt_nx    = r_cnt_q;
`ifdef PLL_FLL_BINSEARCH_EN
        w_step_nx   = r_step;
`endif
        if (w_off) begin
            w_state_nx  = ST_OFF;
            w_locked_nx = 1'b0;
        end else if ((r_state == ST_OFF) || (div != r_div_q)) begin
            // Fresh start or retarget: any in-flight measurement is discarded.
            w_state_nx  = ST_SETTLE;
            w_div_nx    = div;
            w_lock_nx   = '0;
            w_locked_nx = 1'b0;
            w_clear_nx  = 1'b1;
            w_settle_nx = '0;
`ifdef PLL_FLL_BINSEARCH_EN
            w_step_nx   = c_step0;
`endif
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (r_settle == c_settle_l) begin
                        w_state_nx = ST_MEASURE;
                    end else begin
                        w_settle_nx = r_settle + SW'(1);
                    end
                end
                ST_MEASURE: begin
                    if (cnt_valid) begin
                        w_cnt_nx   = cnt_value;
                        w_state_nx = ST_ADJUST;
                    end
                end
                ST_ADJUST: begin
                    if (w_c > w_hi) begin
                        w_level_nx  = w_up;
                        w_lock_nx   = '0;
                        w_locked_nx = 1'b0;
`ifdef PLL_FLL_BINSEARCH_EN
                        w_step_nx   = w_step_half;
`endif
                    end else if (w_c < w_lo) begin
                        w_level_nx  = w_dn;
                        w_lock_nx   = '0;
                        w_locked_nx = 1'b0;
`ifdef PLL_FLL_BINSEARCH_EN
                        w_step_nx   = w_step_half;
`endif
                    end else begin
                        w_lock_nx   = w_lock_inc;
                        w_locked_nx = (w_lock_inc == c_lock_max);
`ifdef PLL_FLL_BINSEARCH_EN
                        w_step_nx   = LW'(1);
`endif
                    end
                    w_state_nx  = ST_SETTLE;
                    w_clear_nx  = 1'b1;
                    w_settle_nx = '0;
                end
                default: w_state_nx = ST_OFF;
            endcase
        end
        w_trim_nx = dco ? ext_trim : therm(w_level_nx);
    end

    always_ff @(posedge osc or negedge resetb) begin
        if (!resetb) begin
            r_state    <= ST_OFF;
            r_level    <= c_l_rst;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_clear    <= 1'b0;
            r_div_q    <= '0;
            r_settle   <= '0;
            r_cnt_q    <= '0;
            r_trim     <= therm(c_l_rst);
`ifdef PLL_FLL_BINSEARCH_EN
            r_step     <= c_step0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_level    <= w_level_nx;
            r_lock_cnt <= w_lock_nx;
            r_locked   <= w_locked_nx;
            r_clear    <= w_clear_nx;
            r_div_q    <= w_div_nx;
            r_settle   <= w_settle_nx;
            r_cnt_q    <= w_cnt_nx;
            r_trim     <= w_trim_nx;
`ifdef PLL_FLL_BINSEARCH_EN
            r_step     <= w_step_nx;
`endif
        end
    end

    assign cnt_clear = r_clear;
    assign trim      = r_trim;
    assign locked    = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_pll_fll_ctrl.sv
// ============================================================================
// Module   : tb_pll_fll_ctrl
// Brief    : Scoreboard bench for pll_fll_ctrl (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_fll_ctrl;

    localparam int SETTLE_CYC = 4;

    logic        osc = 1'b0;
    logic        resetb = 1'b0;
    logic        enable = 1'b0;
    logic        dco = 1'b0;
    logic [4:0]  div = '0;
    logic [25:0] ext_trim = '0;
    logic        cnt_valid = 1'b0;
    logic [7:0]  cnt_value = '0;
    logic        cnt_clear;
    logic [25:0] trim;
    logic        locked;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    pll_fll_ctrl dut (
        .osc       (osc),
        .resetb    (resetb),
        .enable    (enable),
        .dco       (dco),
        .div       (div),
        .ext_trim  (ext_trim),
        .cnt_valid (cnt_valid),
        .cnt_value (cnt_value),
        .cnt_clear (cnt_clear),
        .trim      (trim),
        .locked    (locked)
    );

    always #5 osc = ~osc;

    function automatic logic [25:0] therm(input int l);
        logic [31:0] v;
        v = (32'd1 << l) - 32'd1;
        return v[25:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int l, input bit lk);
        exp_q.push_back(l * 2 + int'(lk));
    endtask

    // Monitor: every cnt_clear pulse presents the post-adjust trim/locked.
    always @(negedge osc) begin
        if (cnt_clear === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_clear: got cnt_clear=1, expected no pulse at %0t", $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("win_trim", 32'(trim), 32'(therm(e / 2)));
                check("win_locked", 32'(locked), 32'(e % 2));
            end
        end
    end

    task automatic wait_clear();
        int k;
        k = 0;
        @(negedge osc);
        while (cnt_clear !== 1'b1 && k < 100) begin
            @(negedge osc);
            k++;
        end
        if (cnt_clear !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL clear_timeout: got no cnt_clear, expected a pulse within 100 cycles");
        end
    endtask

    task automatic window(input int val, input int l, input bit lk);
        wait_clear();
        repeat (SETTLE_CYC + 1) @(negedge osc);
        cnt_value = 8'(val);
        cnt_valid = 1'b1;
        push(l, lk);
        @(negedge osc);
        cnt_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge osc);
        check("rst_trim", 32'(trim), 32'h0001FFF);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_clear", 32'(cnt_clear), 32'd0);
        resetb = 1'b1;
        @(negedge osc);

        // Lock at div=8 with matching count.
        push(13, 1'b0);
        enable = 1'b1;
        div    = 5'd8;
        for (int k = 1; k <= 9; k++) window(8, 13, k >= 8);

        // Fast DCO: climb to 26 and saturate.
        for (int k = 1; k <= 15; k++) window(12, (13 + k > 26) ? 26 : 13 + k, 1'b0);

        // Slow DCO: descend to 0 and saturate.
        for (int k = 1; k <= 27; k++) window(0, (26 - k < 0) ? 0 : 26 - k, 1'b0);

        // Asynchronous reset while in ADJUST.
        wait_clear();
        repeat (SETTLE_CYC + 1) @(negedge osc);
        cnt_value = 8'd0;
        cnt_valid = 1'b1;
        @(posedge osc);
        #2;
        cnt_valid = 1'b0;
        resetb    = 1'b0;
        #1;
        check("areset_trim", 32'(trim), 32'h0001FFF);
        check("areset_locked", 32'(locked), 32'd0);
        check("areset_clear", 32'(cnt_clear), 32'd0);
        enable = 1'b0;
        @(negedge osc);
        resetb = 1'b1;
        repeat (2) @(negedge osc);

        // Relock at div=8 (model DCO count = 34 - 2L).
        push(13, 1'b0);
        enable = 1'b1;
        div    = 5'd8;
        for (int k = 1; k <= 8; k++) window(8, 13, k == 8);

        // Retarget to div=10 mid-window.
        wait_clear();
        repeat (2) @(negedge osc);
        push(13, 1'b0);
        div = 5'd10;
        window(8, 12, 1'b0);
        for (int k = 1; k <= 8; k++) window(10, 12, k == 8);

        // Manual trim bypass.
        wait_clear();
        dco      = 1'b1;
        ext_trim = 26'h155;
        @(negedge osc);
        check("man_trim", 32'(trim), 32'h155);
        check("man_locked", 32'(locked), 32'd0);
        push(12, 1'b0);
        dco = 1'b0;

        // Enable drop coincident with cnt_valid: measurement dropped.
        wait_clear();
        repeat (SETTLE_CYC + 1) @(negedge osc);
        enable    = 1'b0;
        cnt_value = 8'd0;
        cnt_valid = 1'b1;
        @(negedge osc);
        cnt_valid = 1'b0;
        repeat (5) @(negedge osc);
        check("drop_trim", 32'(trim), 32'h0000FFF);
        check("drop_locked", 32'(locked), 32'd0);
        push(12, 1'b0);
        enable = 1'b1;
        window(10, 12, 1'b0);
        wait_clear();
        repeat (3) @(negedge osc);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
